serial_add_ctrl: RTL and testbench

Two-requester controller and round-robin arbiter for a shared bit-serial adder datapath. It accepts operand pairs over valid/ready handshakes and grants one requester at a time. It sequences the adder LSB-first for WIDTH cycles and returns a WIDTH+1-bit sum, tagged with the requester ID, over a held result handshake. It sits between operand producers (switch/register front ends) and the result consumer (display or accumulator logic) in the lab datapath.

---
 rtl/serial_add_pkg.sv | 24 ++
 rtl/serial_add_ctrl_if.sv | 49 ++++
 rtl/serial_fa_slice.sv | 33 +++
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder controller and its
// one-bit full-adder slice.
package serial_add_pkg;

   // Controller states: wait for a request, run the bit-serial add, hold the result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Operand width used when the instantiating level does not override it.
   localparam int DEFAULT_WIDTH = 8;

   // Requester identifiers as they appear on res_id and in the priority pointer.
   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // Majority of three bits: the carry-out of a full adder.
   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle between the operand producers / result consumer and the
// serial adder controller. The master side drives requests and res_ready;
// the slave side (the controller) answers with ready, result and busy.
interface serial_add_ctrl_if #(
   parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);

   // Requester 0
   logic             req0_valid;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_ready;

   // Requester 1
   logic             req1_valid;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_ready;

   // Result channel: {carry_out, sum} tagged with the owning requester
   logic             res_valid;
   logic [WIDTH:0]   res_sum;
   logic             res_id;
   logic             res_ready;

   // Controller activity flag
   logic             busy;

   modport master (
      output req0_valid, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_a, req1_b,
      input  req1_ready,
      input  res_valid, res_sum, res_id,
      output res_ready,
      input  busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_a, req1_b,
      output req1_ready,
      output res_valid, res_sum, res_id,
      input  res_ready,
      output busy
   );

endinterface

// File: rtl/serial_fa_slice.sv
// One-bit full adder with its carry flop. The sum bit is combinational from
// the current operand bits and the stored carry; the carry advances only
// when en is high and is forced to zero by clear at the start of an add.
module serial_fa_slice
   import serial_add_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic s,
   output logic carry
);

   logic carry_reg;

   assign s     = a ^ b ^ carry_reg;
   assign carry = carry_reg;

   // Carry flop: clear wins over en so a fresh add always starts from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         carry_reg <= 1'b0;
      end else if (clear) begin
         carry_reg <= 1'b0;
      end else if (en) begin
         carry_reg <= maj(a, b, carry_reg);
      end
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Two-requester round-robin controller for a shared bit-serial adder.
// An accepted operand pair is added LSB-first over WIDTH cycles and the
// WIDTH+1-bit sum is presented, tagged with the requester, until the
// consumer takes it. Only one operation is in flight at a time.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)(
   input  logic              clk,
   input  logic              reset,
   serial_add_ctrl_if.slave  bus
);

   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_reg;
   logic               ptr_reg;        // requester favoured when both are valid
   logic [CNT_W-1:0]   cnt_reg;        // index of the bit being added
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   sum_reg;        // sum bits enter from the MSB side
   logic               res_valid_reg;
   logic               res_id_reg;
   logic               busy_reg;

   logic               grant0;
   logic               grant1;
   logic               accept;
   logic               shift_en;
   logic               last_bit;
   logic               fa_s;
   logic               fa_carry;

   // Arbiter: grants only in IDLE; the pointer breaks a tie between two valids.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_reg == IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0 = (ptr_reg == REQ0);
            grant1 = (ptr_reg == REQ1);
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   assign accept   = grant0 | grant1;
   assign shift_en = (state_reg == SHIFT);
   assign last_bit = (cnt_reg == CNT_LAST);

   // The carry flop holds the final carry-out once SHIFT ends and keeps it
   // through DONE, so it doubles as the top bit of the result.
   serial_fa_slice u_fa (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .en    (shift_en),
      .a     (a_reg[0]),
      .b     (b_reg[0]),
      .s     (fa_s),
      .carry (fa_carry)
   );

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.res_valid  = res_valid_reg;
   assign bus.res_sum    = {fa_carry, sum_reg};
   assign bus.res_id     = res_id_reg;
   assign bus.busy       = busy_reg;

   // Control FSM with operand, sum, counter and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         ptr_reg       <= REQ0;
         cnt_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         sum_reg       <= '0;
         res_valid_reg <= 1'b0;
         res_id_reg    <= REQ0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  // Operands are sampled only here; later changes are ignored.
                  a_reg      <= grant1 ? bus.req1_a : bus.req0_a;
                  b_reg      <= grant1 ? bus.req1_b : bus.req0_b;
                  res_id_reg <= grant1 ? REQ1 : REQ0;
                  ptr_reg    <= grant1 ? REQ0 : REQ1;
                  cnt_reg    <= '0;
                  busy_reg   <= 1'b1;
                  state_reg  <= SHIFT;
               end
            end

            SHIFT: begin
               a_reg   <= {1'b0, a_reg[WIDTH-1:1]};
               b_reg   <= {1'b0, b_reg[WIDTH-1:1]};
               sum_reg <= {fa_s, sum_reg[WIDTH-1:1]};
               cnt_reg <= cnt_reg + 1'b1;
               if (last_bit) begin
                  res_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end

            DONE: begin
               // Result is frozen here until the consumer takes it.
               if (res_valid_reg && bus.res_ready) begin
                  res_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed table, hand-written corner sequences
// and randomized traffic against a round-robin / plain-addition model.
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   localparam int W = 8;

   logic clk;
   logic reset;

   int checks;
   int errors;

   // Requester state as the model sees it
   logic         v_hold [2];
   logic [W-1:0] a_hold [2];
   logic [W-1:0] b_hold [2];
   int           model_ptr;

   typedef struct {
      int         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0] sum;
   } vec_t;

   vec_t vecs [6];

   serial_add_ctrl_if #(.WIDTH(W)) bus ();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
      v_hold[id] = v;
      a_hold[id] = a;
      b_hold[id] = b;
      if (id == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
      end
   endtask

   // Called just after a negedge with requests already driven. Serves one
   // operation to completion and checks it against the model.
   task automatic serve_one(input int hold, output int wait_cyc, output int got_id, output logic [W:0] got_sum);
      int         exp_id;
      logic [W:0] exp_sum;
      int         lat;
      bit         found;
      exp_id  = (v_hold[0] && v_hold[1]) ? model_ptr : (v_hold[0] ? 0 : 1);
      exp_sum = (W+1)'(a_hold[exp_id]) + (W+1)'(b_hold[exp_id]);
      wait_cyc = -1;
      got_id   = -1;
      got_sum  = '0;
      found    = 0;
      #1;
      for (int k = 0; k < 40; k++) begin
         if (bus.req0_ready || bus.req1_ready) begin
            found = 1;
            wait_cyc = k;
            break;
         end
         @(negedge clk); #1;
      end
      if (!found) begin
         chk("grant_timeout", 32'd0, 32'd1);
         return;
      end
      chk("ready_onehot", 32'(bus.req0_ready && bus.req1_ready), 32'd0);
      got_id = bus.req1_ready ? 1 : 0;
      chk("grant_id", got_id, exp_id);
      @(posedge clk); #1;
      model_ptr = 1 - exp_id;
      // Drop the request and scramble its operands while the add runs.
      set_req(got_id, 1'b0, W'($urandom), W'($urandom));
      found = 0;
      for (lat = 1; lat <= 40; lat++) begin
         @(negedge clk);
         if (lat == 1) chk("busy_rise", 32'(bus.busy), 32'd1);
         if (bus.res_valid) begin
            found = 1;
            break;
         end
      end
      chk("latency", found ? lat : 0, W + 1);
      got_sum = bus.res_sum;
      chk("res_sum", 32'(bus.res_sum), 32'(exp_sum));
      chk("res_id", 32'(bus.res_id), exp_id);
      $display("txn id=%0d a=%02h b=%02h sum=%03h exp=%03h lat=%0d", got_id,
               a_hold[exp_id], b_hold[exp_id], bus.res_sum, exp_sum, lat);
      if (hold > 0) begin
         if (!v_hold[0]) set_req(0, 1'b1, 8'h12, 8'h34);
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_sum", 32'(bus.res_sum), 32'(exp_sum));
            chk("hold_id", 32'(bus.res_id), exp_id);
            chk("hold_no_ready", 32'(bus.req0_ready || bus.req1_ready), 32'd0);
         end
         bus.res_ready = 1'b1;
      end
      @(negedge clk);
      chk("res_valid_drop", 32'(bus.res_valid), 32'd0);
      chk("busy_fall", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int         wc;
      int         gid;
      logic [W:0] gs;
      int         seen;

      checks = 0;
      errors = 0;
      model_ptr = 0;
      bus.res_ready = 1'b1;
      set_req(0, 1'b0, '0, '0);
      set_req(1, 1'b0, '0, '0);

      vecs[0] = '{0, 8'hFF, 8'h01, 9'h100};
      vecs[1] = '{1, 8'hA5, 8'h5A, 9'h0FF};
      vecs[2] = '{1, 8'd200, 8'd100, 9'h12C};
      vecs[3] = '{0, 8'h00, 8'h00, 9'h000};
      vecs[4] = '{1, 8'hFF, 8'hFF, 9'h1FE};
      vecs[5] = '{0, 8'h80, 8'h80, 9'h100};

      // Reset values
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_sum", 32'(bus.res_sum), 32'd0);
      chk("rst_res_id", 32'(bus.res_id), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed table; the first entry starts on the cycle reset lifts.
      for (int i = 0; i < 6; i++) begin
         set_req(vecs[i].id, 1'b1, vecs[i].a, vecs[i].b);
         serve_one(0, wc, gid, gs);
         chk("tbl_wait", wc, 0);
         chk("tbl_id", gid, vecs[i].id);
         chk("tbl_sum", 32'(gs), 32'(vecs[i].sum));
      end

      // Reset in the middle of SHIFT aborts the add.
      set_req(1, 1'b1, 8'hFF, 8'h01);
      #1;
      chk("abort_ready", 32'(bus.req1_ready), 32'd1);
      @(posedge clk); #1;
      set_req(1, 1'b0, 8'h00, 8'h00);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
      chk("abort_res_sum", 32'(bus.res_sum), 32'd0);
      chk("abort_res_id", 32'(bus.res_id), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      model_ptr = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (bus.res_valid) seen++;
      end
      chk("abort_no_result", seen, 0);

      // Both valid after reset: req0 first, loser keeps valid and goes next.
      set_req(0, 1'b1, W'($urandom), W'($urandom));
      set_req(1, 1'b1, W'($urandom), W'($urandom));
      serve_one(0, wc, gid, gs);
      chk("rr_first", gid, 0);
      serve_one(0, wc, gid, gs);
      chk("rr_second", gid, 1);
      chk("rr_second_wait", wc, 0);
      set_req(0, 1'b1, 8'hFF, 8'hFF);
      serve_one(0, wc, gid, gs);
      chk("post_abort_sum", 32'(gs), 32'h1FE);

      // Result held with res_ready low while req0 waits.
      set_req(1, 1'b1, 8'hC3, 8'h3C);
      bus.res_ready = 1'b0;
      serve_one(5, wc, gid, gs);
      serve_one(0, wc, gid, gs);
      chk("after_hold_wait", wc, 0);
      chk("after_hold_id", gid, 0);

      // Randomized traffic
      for (int i = 0; i < 24; i++) begin
         for (int r = 0; r < 2; r++) begin
            if (!v_hold[r] && ($urandom_range(0, 1) == 1))
               set_req(r, 1'b1, W'($urandom), W'($urandom));
         end
         if (!v_hold[0] && !v_hold[1])
            set_req(int'($urandom_range(0, 1)), 1'b1, W'($urandom), W'($urandom));
         serve_one(0, wc, gid, gs);
         chk("rand_wait", wc, 0);
      end
      for (int i = 0; i < 2; i++) begin
         if (v_hold[0] || v_hold[1]) serve_one(0, wc, gid, gs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
